// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants, scan state encoding and control-word builder
//
// Purpose: definitions shared by the 8-channel ADC scan controller and its
//          serial frame engine.
// Contents:
//   N_CH, CH_W        number of mux channels and width of a channel index
//   DATA_BITS         width of one ADC result
//   FRAME_BITS        SCLK periods per serial frame
//   CTRL_BITS         width of the ADC control word
//   scan_state_t      scan FSM state encoding
//   ctrl_word()       control word that selects a channel: {2'b00, ch, 11'b0}
package adc_pkg;

   localparam int N_CH       = 8;
   localparam int CH_W       = $clog2(N_CH);
   localparam int DATA_BITS  = 12;
   localparam int FRAME_BITS = 16;
   localparam int CTRL_BITS  = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } scan_state_t;

   // Channel address sits in bits 13:11, everything else is zero.
   function automatic logic [CTRL_BITS-1:0] ctrl_word(input logic [CH_W-1:0] ch);
      return {2'b00, ch, 11'b0};
   endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// rtl/adc_spi_frame.sv - one SPI-style ADC frame: SCLK generator plus TX/RX shifters
//
// Purpose: on a start pulse, drops cs_n and runs FRAME_BITS SCLK periods.
//          SCLK idles high; each period is a falling edge then a rising edge,
//          SCLK_HALF clk cycles apart. din changes on falling edges (MSB
//          first), dout is sampled on rising edges (MSB first). After the last
//          rising edge cs_n returns high on the next clk together with a
//          one-clk done pulse.
// Ports:
//   clk, rst_l     clock, asynchronous active-low reset
//   start          one-clk request to run a frame (ignored never overlaps)
//   tx_word        word shifted out on din, loaded at start
//   dout           serial data from the ADC
//   sclk, cs_n     serial clock and chip select to the ADC
//   din            serial control data to the ADC
//   done           one-clk pulse, frame finished, rx_data valid
//   rx_data        last DATA_BITS bits received in the frame
module adc_spi_frame #(
   parameter int SCLK_HALF  = 3,
   parameter int FRAME_BITS = adc_pkg::FRAME_BITS,
   parameter int DATA_BITS  = adc_pkg::DATA_BITS
) (
   input  logic                  clk,
   input  logic                  rst_l,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] tx_word,
   input  logic                  dout,
   output logic                  sclk,
   output logic                  cs_n,
   output logic                  din,
   output logic                  done,
   output logic [DATA_BITS-1:0]  rx_data
);

   localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);
   localparam logic [7:0] EDGE_LAST = 8'(2 * FRAME_BITS);

   logic                  active;
   logic [7:0]            half_cnt;
   logic [7:0]            edge_cnt;
   logic [FRAME_BITS-1:0] tx_sr;

   // rx_data is only DATA_BITS wide: shifting the whole frame through it
   // leaves exactly the trailing DATA_BITS bits, the leading bits fall off.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         active   <= 1'b0;
         half_cnt <= 8'd0;
         edge_cnt <= 8'd0;
         tx_sr    <= '0;
         rx_data  <= '0;
         sclk     <= 1'b1;
         cs_n     <= 1'b1;
         din      <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            active   <= 1'b1;
            cs_n     <= 1'b0;
            sclk     <= 1'b1;
            half_cnt <= 8'd0;
            edge_cnt <= 8'd0;
            tx_sr    <= tx_word;
            rx_data  <= '0;
            din      <= 1'b0;
         end else if (active) begin
            if (edge_cnt == EDGE_LAST) begin
               // SCLK is already back high after the final rising edge.
               active <= 1'b0;
               cs_n   <= 1'b1;
               din    <= 1'b0;
               done   <= 1'b1;
            end else if (half_cnt == HALF_LAST) begin
               half_cnt <= 8'd0;
               edge_cnt <= edge_cnt + 8'd1;
               sclk     <= ~sclk;
               if (sclk) begin
                  din   <= tx_sr[FRAME_BITS-1];
                  tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
               end else begin
                  rx_data <= {rx_data[DATA_BITS-2:0], dout};
               end
            end else begin
               half_cnt <= half_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/adc_8ch_scan.sv
// rtl/adc_8ch_scan.sv - 8-channel mux + 12-bit serial ADC scan controller
//
// Purpose: a rising edge on sync (accepted only when idle) scans channels
//          0..7: for each one it sets CD_MUX, waits CS_GAP clk for the mux to
//          settle, runs one serial frame and stores the result. When all
//          eight are in, they are published together on ch_data with a
//          one-clk ch_valid pulse.
// Ports:
//   clk, rst_l     clock, asynchronous active-low reset
//   sync           scan request (asynchronous, synchronised here)
//   DOUT           ADC serial data
//   SCLK           ADC serial clock, idles high
//   CS_ADC         ADC chip select, active low
//   CD_MUX         external mux channel address, holds after a scan
//   DIN            ADC control word, serial
//   ch_data        channel n result in bits [12n+11:12n], raw unsigned codes
//   ch_valid       one-clk pulse when ch_data has been updated
//   busy           high while a scan is in progress
module adc_8ch_scan #(
   parameter int SCLK_HALF  = 3,
   parameter int FRAME_BITS = adc_pkg::FRAME_BITS,
   parameter int DATA_BITS  = adc_pkg::DATA_BITS,
   parameter int CS_GAP     = 4
) (
   input  logic                                clk,
   input  logic                                rst_l,
   input  logic                                sync,
   input  logic                                DOUT,
   output logic                                SCLK,
   output logic                                CS_ADC,
   output logic [adc_pkg::CH_W-1:0]            CD_MUX,
   output logic                                DIN,
   output logic [adc_pkg::N_CH*DATA_BITS-1:0]  ch_data,
   output logic                                ch_valid,
   output logic                                busy
);

   import adc_pkg::*;

   localparam logic [7:0]      GAP_LAST = 8'(CS_GAP - 1);
   localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CH - 1);

   scan_state_t state_q, state_d;

   logic                        sync_q1, sync_q2, sync_q3;
   logic                        sync_rise;
   logic [7:0]                  setup_cnt;
   logic [CH_W-1:0]             ch_idx;
   logic [N_CH*DATA_BITS-1:0]   result_buf;
   logic [N_CH*DATA_BITS-1:0]   buf_next;
   logic [FRAME_BITS-1:0]       tx_word;
   logic [DATA_BITS-1:0]        rx_data;
   logic                        frame_start;
   logic                        frame_done;

   // Two flops to synchronise, a third to detect the rising edge.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         sync_q3 <= 1'b0;
      end else begin
         sync_q1 <= sync;
         sync_q2 <= sync_q1;
         sync_q3 <= sync_q2;
      end
   end

   assign sync_rise = sync_q2 & ~sync_q3;

   // ---------------- scan FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- scan FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (sync_rise) state_d = ST_SETUP;
         ST_SETUP: if (setup_cnt == GAP_LAST) state_d = ST_SHIFT;
         ST_SHIFT: if (frame_done) state_d = ST_GAP;
         ST_GAP:   state_d = (ch_idx == CH_LAST) ? ST_DONE : ST_SETUP;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- scan FSM: outputs ----------------
   always_comb begin
      frame_start = (state_q == ST_SETUP) && (setup_cnt == GAP_LAST);
      busy        = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                    (state_q == ST_GAP);
   end

   // Control word occupies the top CTRL_BITS of the frame.
   always_comb begin
      tx_word = '0;
      tx_word[FRAME_BITS-1 -: CTRL_BITS] = ctrl_word(ch_idx);
   end

   // Buffer contents after the current channel's result is merged in; used
   // both to update the buffer and, on the last channel, to publish all
   // eight slots in the same clk.
   always_comb begin
      buf_next = result_buf;
      buf_next[ch_idx*DATA_BITS +: DATA_BITS] = rx_data;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         setup_cnt  <= 8'd0;
         ch_idx     <= '0;
         CD_MUX     <= '0;
         result_buf <= '0;
         ch_data    <= '0;
         ch_valid   <= 1'b0;
      end else begin
         ch_valid <= 1'b0;
         if (state_q == ST_SETUP) setup_cnt <= setup_cnt + 8'd1;
         else                     setup_cnt <= 8'd0;

         case (state_q)
            ST_IDLE: begin
               if (sync_rise) ch_idx <= '0;
            end
            ST_SETUP: begin
               CD_MUX <= ch_idx;
            end
            ST_GAP: begin
               result_buf <= buf_next;
               ch_idx     <= ch_idx + 1'b1;
               // Registered here so ch_data and ch_valid are visible during
               // DONE, the same cycle busy drops.
               if (ch_idx == CH_LAST) begin
                  ch_data  <= buf_next;
                  ch_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   adc_spi_frame #(
      .SCLK_HALF  (SCLK_HALF),
      .FRAME_BITS (FRAME_BITS),
      .DATA_BITS  (DATA_BITS)
   ) u_frame (
      .clk     (clk),
      .rst_l   (rst_l),
      .start   (frame_start),
      .tx_word (tx_word),
      .dout    (DOUT),
      .sclk    (SCLK),
      .cs_n    (CS_ADC),
      .din     (DIN),
      .done    (frame_done),
      .rx_data (rx_data)
   );

endmodule

// File: tb/tb_adc_8ch_scan.sv
// tb/tb_adc_8ch_scan.sv - self-checking bench for adc_8ch_scan
module tb_adc_8ch_scan;

   logic        clk;
   logic        rst_l;
   logic        sync;
   logic        DOUT;
   logic        SCLK;
   logic        CS_ADC;
   logic [2:0]  CD_MUX;
   logic        DIN;
   logic [95:0] ch_data;
   logic        ch_valid;
   logic        busy;

   adc_8ch_scan dut (
      .clk      (clk),
      .rst_l    (rst_l),
      .sync     (sync),
      .DOUT     (DOUT),
      .SCLK     (SCLK),
      .CS_ADC   (CS_ADC),
      .CD_MUX   (CD_MUX),
      .DIN      (DIN),
      .ch_data  (ch_data),
      .ch_valid (ch_valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- ADC model and bus monitors ----------------
   logic        dmode;       // 0: constant dcode, 1: dcode + channel
   logic [15:0] dcode;
   logic [15:0] adc_word;
   int          bit_m;
   int          win_cnt;
   int          cur;
   int          idle_toggles;
   int          valid_cnt;
   int          falls    [16];
   int          rises    [16];
   int          mux_seen [16];
   logic [15:0] din_word [16];

   always @(negedge CS_ADC) begin
      if (win_cnt < 16) begin
         cur           = win_cnt;
         mux_seen[cur] = int'(CD_MUX);
         falls[cur]    = 0;
         rises[cur]    = 0;
         din_word[cur] = 16'h0;
      end
      win_cnt++;
      adc_word = dmode ? (dcode + 16'(CD_MUX)) : dcode;
      bit_m    = 15;
   end

   always @(negedge SCLK) begin
      if (CS_ADC === 1'b0) begin
         falls[cur]++;
         if (bit_m >= 0) DOUT = adc_word[bit_m];
         bit_m--;
      end else begin
         idle_toggles++;
      end
   end

   always @(posedge SCLK) begin
      if (CS_ADC === 1'b0) begin
         rises[cur]++;
         din_word[cur] = {din_word[cur][14:0], DIN};
      end else begin
         idle_toggles++;
      end
   end

   always @(posedge clk) if (ch_valid === 1'b1) valid_cnt++;

   task automatic reset_mon();
      win_cnt      = 0;
      cur          = 0;
      idle_toggles = 0;
      valid_cnt    = 0;
   endtask

   task automatic pulse_sync();
      @(negedge clk);
      sync = 1'b1;
      repeat (3) @(negedge clk);
      sync = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ch_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_frames(input int base);
      for (int n = 0; n < 8; n++) begin
         check($sformatf("sclk_falls_w%0d", base + n), 96'(falls[base + n]), 96'd16);
         check($sformatf("sclk_rises_w%0d", base + n), 96'(rises[base + n]), 96'd16);
         check($sformatf("cd_mux_w%0d", base + n), 96'(mux_seen[base + n]), 96'(n));
         check($sformatf("din_word_w%0d", base + n), 96'(din_word[base + n]), 96'(n << 11));
      end
   endtask

   task automatic check_idle_outputs(input string tag, input logic [95:0] exp_data);
      check({tag, "_sclk"},     96'(SCLK),     96'd1);
      check({tag, "_cs"},       96'(CS_ADC),   96'd1);
      check({tag, "_din"},      96'(DIN),      96'd0);
      check({tag, "_busy"},     96'(busy),     96'd0);
      check({tag, "_ch_valid"}, 96'(ch_valid), 96'd0);
      check({tag, "_ch_data"},  ch_data,       exp_data);
   endtask

   typedef struct packed {
      logic        mode;
      logic [15:0] code;
      logic [95:0] exp_data;
   } vec_t;

   vec_t vecs [4];

   initial begin
      bit ok;

      vecs[0].mode = 1'b0; vecs[0].code = 16'h0ABC; vecs[0].exp_data = {8{12'hABC}};
      vecs[1].mode = 1'b1; vecs[1].code = 16'h0100;
      vecs[1].exp_data = {12'h107, 12'h106, 12'h105, 12'h104,
                          12'h103, 12'h102, 12'h101, 12'h100};
      vecs[2].mode = 1'b0; vecs[2].code = 16'hFFFF; vecs[2].exp_data = {8{12'hFFF}};
      vecs[3].mode = 1'b0; vecs[3].code = 16'hF123; vecs[3].exp_data = {8{12'h123}};

      rst_l = 1'b0;
      sync  = 1'b0;
      DOUT  = 1'b0;
      dmode = 1'b0;
      dcode = 16'h0;
      bit_m = 15;
      reset_mon();
      repeat (5) @(negedge clk);
      rst_l = 1'b1;
      reset_mon();

      // Reset state, sync held low.
      repeat (100) @(negedge clk);
      check_idle_outputs("reset", 96'h0);
      check("reset_cd_mux", 96'(CD_MUX), 96'd0);
      check("reset_sclk_toggles", 96'(idle_toggles), 96'd0);
      check("reset_no_frames", 96'(win_cnt), 96'd0);

      // Table-driven full scans.
      for (int v = 0; v < 4; v++) begin
         reset_mon();
         dmode = vecs[v].mode;
         dcode = vecs[v].code;
         pulse_sync();
         @(negedge clk);
         check($sformatf("v%0d_busy_start", v), 96'(busy), 96'd1);
         wait_valid(3000, ok);
         check($sformatf("v%0d_scan_done", v), 96'(ok), 96'd1);
         check($sformatf("v%0d_busy_at_valid", v), 96'(busy), 96'd0);
         check($sformatf("v%0d_data_at_valid", v), ch_data, vecs[v].exp_data);
         repeat (20) @(negedge clk);
         check($sformatf("v%0d_frames", v), 96'(win_cnt), 96'd8);
         check_frames(0);
         check($sformatf("v%0d_valid_cnt", v), 96'(valid_cnt), 96'd1);
         check($sformatf("v%0d_cd_mux_hold", v), 96'(CD_MUX), 96'd7);
         check($sformatf("v%0d_idle_toggles", v), 96'(idle_toggles), 96'd0);
         check_idle_outputs($sformatf("v%0d_end", v), vecs[v].exp_data);
      end

      // Second sync 200 clk into a scan is ignored.
      reset_mon();
      dmode = 1'b0;
      dcode = 16'h0555;
      pulse_sync();
      repeat (200) @(negedge clk);
      pulse_sync();
      wait_valid(3000, ok);
      check("ign_scan_done", 96'(ok), 96'd1);
      repeat (1100) @(negedge clk);
      check("ign_valid_cnt", 96'(valid_cnt), 96'd1);
      check("ign_frames", 96'(win_cnt), 96'd8);
      check_idle_outputs("ign_end", {8{12'h555}});

      // Reset during channel 4 aborts at once, publishes nothing.
      reset_mon();
      dcode = 16'h0777;
      pulse_sync();
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (win_cnt == 5) begin
            ok = 1'b1;
            break;
         end
      end
      check("rst_reached_ch4", 96'(ok), 96'd1);
      check("rst_ch4_mux", 96'(CD_MUX), 96'd4);
      repeat (20) @(negedge clk);
      rst_l = 1'b0;
      #1;
      check_idle_outputs("rst_now", 96'h0);
      check("rst_now_cd_mux", 96'(CD_MUX), 96'd0);
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      reset_mon();
      repeat (900) @(negedge clk);
      check("rst_no_valid", 96'(valid_cnt), 96'd0);
      check("rst_no_frames", 96'(win_cnt), 96'd0);
      check_idle_outputs("rst_after", 96'h0);
      pulse_sync();
      wait_valid(3000, ok);
      check("rst_fresh_done", 96'(ok), 96'd1);
      repeat (20) @(negedge clk);
      check("rst_fresh_frames", 96'(win_cnt), 96'd8);
      check_frames(0);
      check("rst_fresh_data", ch_data, {8{12'h777}});

      // Two sync pulses 1000 clk apart give two complete scans.
      reset_mon();
      dmode = 1'b1;
      dcode = 16'h0100;
      pulse_sync();
      repeat (996) @(negedge clk);
      check("b2b_first_valid", 96'(valid_cnt), 96'd1);
      check("b2b_idle_between", 96'(busy), 96'd0);
      pulse_sync();
      wait_valid(3000, ok);
      check("b2b_second_done", 96'(ok), 96'd1);
      repeat (20) @(negedge clk);
      check("b2b_valid_cnt", 96'(valid_cnt), 96'd2);
      check("b2b_frames", 96'(win_cnt), 96'd16);
      check_frames(8);
      check("b2b_idle_toggles", 96'(idle_toggles), 96'd0);
      check_idle_outputs("b2b_end", vecs[1].exp_data);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
